// File: rtl/odyssey_analog_conditioner_pkg.sv
// Shared types and helpers for the Odyssey analog conditioner.
// FSM state enum, centre value, saturating negate.
package odyssey_analog_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PROC,
    COMMIT
  } state_t;

  function automatic int centre(input int w);
    return 1 << (w - 1);
  endfunction

  // -2^(w-1) has no positive twin; clip it to the max.
  function automatic int sat_neg(input int v, input int w);
    if (v == -centre(w))
      return centre(w) - 1;
    return -v;
  endfunction

endpackage

// File: rtl/odyssey_analog_conditioner_if.sv
// Bus bundle between hps_io axes and the Odyssey core.
// master: raw_in/vsync/deadzone/invert out; slave: results out.
interface odyssey_analog_conditioner_if #(
  parameter int NUM_CH     = 8,
  parameter int DATA_W     = 8,
  parameter int DEADZONE_W = 4
);

  logic [NUM_CH*DATA_W-1:0] raw_in;
  logic                     vsync;
  logic [DEADZONE_W-1:0]    deadzone;
  logic [NUM_CH-1:0]        invert;
  logic [NUM_CH*DATA_W-1:0] axis_out;
  logic                     out_valid;
  logic                     busy;
  logic                     overrun;

  modport master (
    output raw_in, vsync, deadzone, invert,
    input  axis_out, out_valid, busy, overrun
  );

  modport slave (
    input  raw_in, vsync, deadzone, invert,
    output axis_out, out_valid, busy, overrun
  );

endinterface

// File: rtl/odyssey_analog_conditioner_ch.sv
// Per-axis function: invert, deadzone, offset-binary, slew.
// Ports: v/inv/deadzone(/prev with ANALOG_SLEW_EN) in, u out.
module odyssey_analog_ch
  import odyssey_analog_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int DEADZONE_W = 4,
  parameter int SLEW_MAX   = 16
) (
  input  logic [DATA_W-1:0]     v,
  input  logic                  inv,
  input  logic [DEADZONE_W-1:0] deadzone,
`ifdef ANALOG_SLEW_EN
  input  logic [DATA_W-1:0]     prev,
`endif
  output logic [DATA_W-1:0]     u
);

  localparam int CTR  = centre(DATA_W);
  localparam int UMAX = 2 * CTR - 1;

  int s;
  int m;
  int r;
`ifdef ANALOG_SLEW_EN
  int lo;
  int hi;
`endif

  always_comb begin
    s = int'($signed(v));
    if (inv)
      s = sat_neg(s, DATA_W);
    m = (s < 0) ? -s : s;
    if (m <= int'({1'b0, deadzone}))
      s = 0;
    r = s + CTR;
`ifdef ANALOG_SLEW_EN
    lo = int'({1'b0, prev}) - SLEW_MAX;
    hi = int'({1'b0, prev}) + SLEW_MAX;
    if (lo < 0)
      lo = 0;
    if (hi > UMAX)
      hi = UMAX;
    if (r < lo)
      r = lo;
    if (r > hi)
      r = hi;
`endif
    u = DATA_W'(r);
  end

endmodule

// File: rtl/odyssey_analog_conditioner.sv
// Frame-synchronous analog axis conditioner (optional ANALOG_SLEW_EN).
// Ports: clk, reset (async high), bus (slave modport).
module odyssey_analog_conditioner
  import odyssey_analog_pkg::*;
#(
  parameter int NUM_CH     = 8,
  parameter int DATA_W     = 8,
  parameter int DEADZONE_W = 4,
  parameter int SLEW_MAX   = 16
) (
  input logic clk,
  input logic reset,
  odyssey_analog_conditioner_if.slave bus
);

  localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [IW-1:0] LAST = IW'(NUM_CH - 1);
  localparam logic [DATA_W-1:0] CTR = DATA_W'(centre(DATA_W));

  state_t state;
  state_t state_d;

  logic vsync_q;
  logic rise;
  logic busy;
  logic commit;
  logic out_valid;
  logic overrun;

  logic [IW-1:0] ch_idx;
  logic [NUM_CH-1:0] inv_q;
  logic [NUM_CH-1:0][DATA_W-1:0] shadow;
  logic [NUM_CH-1:0][DATA_W-1:0] work;
  logic [NUM_CH-1:0][DATA_W-1:0] axis_q;
  logic [DATA_W-1:0] u;

  assign rise = bus.vsync & ~vsync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    if (rise) state_d = PROC;
      PROC:    if (ch_idx == LAST) state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy   = (state != IDLE);
    commit = (state == COMMIT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vsync_q   <= 1'b0;
      ch_idx    <= '0;
      inv_q     <= '0;
      shadow    <= '0;
      work      <= '0;
      axis_q    <= {NUM_CH{CTR}};
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      vsync_q   <= bus.vsync;
      out_valid <= commit;
      // No re-queue: a rise during a set is dropped and flagged.
      if (rise && busy)
        overrun <= 1'b1;
      if (!busy && rise) begin
        shadow <= bus.raw_in;
        inv_q  <= bus.invert;
        ch_idx <= '0;
      end
      if (state == PROC) begin
        work[ch_idx] <= u;
        ch_idx       <= ch_idx + 1'b1;
      end
      if (commit)
        axis_q <= work;
    end
  end

  odyssey_analog_ch #(
    .DATA_W     (DATA_W),
    .DEADZONE_W (DEADZONE_W),
    .SLEW_MAX   (SLEW_MAX)
  ) u_ch (
    .v        (shadow[ch_idx]),
    .inv      (inv_q[ch_idx]),
    .deadzone (bus.deadzone),
`ifdef ANALOG_SLEW_EN
    .prev     (axis_q[ch_idx]),
`endif
    .u        (u)
  );

  assign bus.axis_out  = axis_q;
  assign bus.out_valid = out_valid;
  assign bus.busy      = busy;
  assign bus.overrun   = overrun;

endmodule

// File: tb/tb_odyssey_analog_conditioner.sv
// Directed bench for odyssey_analog_conditioner.
// Default build checks function/overrun/reset; slew build checks ramps.
module tb_odyssey_analog_conditioner;

  logic clk = 1'b0;
  logic reset;

  odyssey_analog_conditioner_if bus ();

  odyssey_analog_conditioner dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic expect_eq(input string tag,
                           input logic [31:0] got,
                           input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic check_axes(input string tag,
                            input logic [63:0] exp);
    for (int i = 0; i < 8; i++)
      expect_eq($sformatf("%s_ch%0d", tag, i),
                32'(bus.axis_out[i*8 +: 8]),
                32'(exp[i*8 +: 8]));
  endtask

  task automatic run_frame(input logic [63:0] raw,
                           input logic [7:0] inv,
                           input bit clash,
                           input logic [63:0] alt,
                           output int nbusy,
                           output int nvalid,
                           output int vpos);
    nbusy  = 0;
    nvalid = 0;
    vpos   = 0;
    @(negedge clk);
    bus.raw_in = raw;
    bus.invert = inv;
    bus.vsync  = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (bus.busy) nbusy++;
      if (bus.out_valid) begin
        nvalid++;
        if (vpos == 0) vpos = k;
      end
      if (k == 1) bus.vsync = 1'b0;
      if (clash && k == 3) begin
        bus.vsync  = 1'b1;
        bus.raw_in = alt;
      end
      if (clash && k == 4) bus.vsync = 1'b0;
    end
  endtask

  int nb, nv, vp;

  initial begin
    reset        = 1'b1;
    bus.vsync    = 1'b0;
    bus.raw_in   = '0;
    bus.invert   = '0;
    bus.deadzone = 4'd4;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    check_axes("rst", {8{8'h80}});
    expect_eq("rst_valid", 32'(bus.out_valid), 0);
    expect_eq("rst_busy", 32'(bus.busy), 0);
    expect_eq("rst_ovr", 32'(bus.overrun), 0);

`ifdef ANALOG_SLEW_EN
    begin
      int e;
      bus.deadzone = 4'd0;
      e = 8'h80;
      for (int f = 0; f < 8; f++) begin
        run_frame({56'h0, 8'h7F}, 8'h00, 1'b0, '0, nb, nv, vp);
        e = (e + 16 > 255) ? 255 : e + 16;
        expect_eq($sformatf("up%0d_ch0", f),
                  32'(bus.axis_out[7:0]), 32'(e));
        expect_eq($sformatf("up%0d_ch1", f),
                  32'(bus.axis_out[15:8]), 32'h80);
      end
      for (int f = 0; f < 16; f++) begin
        run_frame({56'h0, 8'h80}, 8'h00, 1'b0, '0, nb, nv, vp);
        e = (e < 16) ? 0 : e - 16;
        expect_eq($sformatf("dn%0d_ch0", f),
                  32'(bus.axis_out[7:0]), 32'(e));
      end
    end
`else
    run_frame(64'hE0_05_80_7F_FC_FB_04_10, 8'h00, 1'b0, '0,
              nb, nv, vp);
    expect_eq("f1_busy_cycles", 32'(nb), 9);
    expect_eq("f1_valid_count", 32'(nv), 1);
    expect_eq("f1_valid_pos", 32'(vp), 10);
    check_axes("f1", 64'h60_85_00_FF_80_7B_80_90);

    run_frame(64'hE0_05_80_7F_FC_FB_80_10, 8'h0E, 1'b0, '0,
              nb, nv, vp);
    check_axes("f2", 64'h60_85_00_FF_80_85_FF_90);

    run_frame(64'hE0_05_80_7F_FC_FB_7F_10, 8'h02, 1'b0, '0,
              nb, nv, vp);
    check_axes("f3", 64'h60_85_00_FF_80_7B_01_90);
    expect_eq("f3_ovr", 32'(bus.overrun), 0);

    run_frame(64'h10_00_00_00_00_00_00_20, 8'h00, 1'b1,
              64'h40_00_00_00_00_00_00_30, nb, nv, vp);
    expect_eq("f4_valid_count", 32'(nv), 1);
    expect_eq("f4_ovr", 32'(bus.overrun), 1);
    check_axes("f4", 64'h90_80_80_80_80_80_80_A0);

    run_frame(64'h40_00_00_00_00_00_00_30, 8'h00, 1'b0, '0,
              nb, nv, vp);
    expect_eq("f5_ovr_sticky", 32'(bus.overrun), 1);
    check_axes("f5", 64'hC0_80_80_80_80_80_80_B0);

    @(negedge clk);
    bus.raw_in = 64'h7F_7F_7F_7F_7F_7F_7F_7F;
    bus.vsync  = 1'b1;
    @(negedge clk);
    bus.vsync = 1'b0;
    @(negedge clk);
    expect_eq("mid_busy", 32'(bus.busy), 1);
    reset = 1'b1;
    #1;
    check_axes("mid_rst", {8{8'h80}});
    expect_eq("mid_rst_valid", 32'(bus.out_valid), 0);
    expect_eq("mid_rst_busy", 32'(bus.busy), 0);
    expect_eq("mid_rst_ovr", 32'(bus.overrun), 0);
    @(negedge clk);
    reset = 1'b0;
    nv = 0;
    nb = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.out_valid) nv++;
      if (bus.busy) nb++;
    end
    expect_eq("post_rst_valid", 32'(nv), 0);
    expect_eq("post_rst_busy", 32'(nb), 0);
    check_axes("post_rst", {8{8'h80}});
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
